mcp_2515_spi_slave: RTL

SPI mode-0 responder that emulates the MCP2515 register-access command set over a 128-byte register file. It sits at the far end of the MCP2515 SPI link, driven by the existing MCP2515 SPI master. It is used for FPGA loopback bring-up and as a CAN-controller stand-in. Local logic can inject register contents and observe every SPI-originated register write.

---
 rtl/mcp_2515_pkg.sv | 38 +++
 rtl/spi_slave_byte_shifter.sv | 99 +++++++++
 rtl/mcp_2515_spi_slave.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mcp_2515_pkg.sv
// Shared definitions for the MCP2515 SPI register-access responder.
package mcp_2515_pkg;

  localparam logic [7:0] OP_RESET       = 8'hC0;
  localparam logic [7:0] OP_READ        = 8'h03;
  localparam logic [7:0] OP_WRITE       = 8'h02;
  localparam logic [7:0] OP_BIT_MODIFY  = 8'h05;
  localparam logic [7:0] OP_READ_STATUS = 8'hA0;

  localparam logic [6:0] ADDR_CANSTAT = 7'h0E;
  localparam logic [6:0] ADDR_CANCTRL = 7'h0F;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_BM_MASK,
    ST_BM_DATA,
    ST_STATUS,
    ST_DONE,
    ST_IGNORE
  } spi_state_t;

  typedef enum logic [1:0] {
    CMD_READ,
    CMD_WRITE,
    CMD_BIT_MODIFY
  } spi_cmd_t;

  function automatic logic [7:0] bit_modify(input logic [7:0] cur,
                                            input logic [7:0] mask,
                                            input logic [7:0] data);
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/spi_slave_byte_shifter.sv
// SPI mode-0 byte shifter: input synchronisers, SCK edge detection,
// MSB-first receive with a byte_done strobe, and a transmit register
// that advances on SCK fall.
module spi_slave_byte_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       spi_sck_in,
  input  logic       spi_cs_n_in,
  input  logic       spi_sdi_in,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       cs_active,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       sdo
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sck_prev;
  logic                   sdi_prev;
  logic                   sck_rise;
  logic                   sck_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sh;
  logic [7:0]             tx_sh;

  assign cs_active = ~cs_sync[SYNC_STAGES-1];

  // Synchronise the pins; CS comes out of reset deasserted.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sdi_sync <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_in};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_in};
    end
  end

  // Registered edge strobes; sdi_prev is the data bit aligned with sck_rise.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sck_prev <= 1'b0;
      sdi_prev <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
    end else begin
      sck_prev <= sck_sync[SYNC_STAGES-1];
      sdi_prev <= sdi_sync[SYNC_STAGES-1];
      sck_rise <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
      sck_fall <= ~sck_sync[SYNC_STAGES-1] & sck_prev;
    end
  end

  // Receive: shift on SCK rise, strobe byte_done after the 8th bit.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (!cs_active) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh   <= {rx_sh[5:0], sdi_prev};
        if (bit_cnt == 3'd7) begin
          rx_byte   <= {rx_sh, sdi_prev};
          byte_done <= 1'b1;
        end
      end
    end
  end

  // Transmit: loaded at byte boundary, MSB presented on the following SCK fall.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_sh <= '0;
      sdo   <= 1'b0;
    end else if (!cs_active) begin
      tx_sh <= '0;
      sdo   <= 1'b0;
    end else if (tx_load) begin
      tx_sh <= tx_byte;
    end else if (sck_fall) begin
      sdo   <= tx_sh[7];
      tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/mcp_2515_spi_slave.sv
// MCP2515-style SPI register-access responder over a 128-byte register file.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | CS high, waiting for a transaction
// ST_OPCODE  | receiving the command byte
// ST_ADDR    | receiving the register address (READ/WRITE/BIT MODIFY)
// ST_RD_DATA | shifting out register bytes, address auto-increments
// ST_WR_DATA | each received byte writes a register, address auto-increments
// ST_BM_MASK | receiving the bit-modify mask
// ST_BM_DATA | receiving the bit-modify data, commit on completion
// ST_STATUS  | repeatedly shifting out the captured status byte
// ST_DONE    | command complete, remaining bytes ignored until CS high
// ST_IGNORE  | unsupported opcode, ignored until CS high
module mcp_2515_spi_slave
  import mcp_2515_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CANSTAT_RST = 8'h80,
  parameter logic [7:0] CANCTRL_RST = 8'h87
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       spi_sck_in,
  input  logic       spi_cs_n_in,
  input  logic       spi_sdi_in,
  output logic       spi_sdo_out,
  output logic       spi_sdo_oe_out,
  input  logic [7:0] status_in,
  output logic       reg_wr_valid_out,
  output logic [6:0] reg_wr_addr_out,
  output logic [7:0] reg_wr_data_out,
  input  logic       host_wr_en_in,
  input  logic [6:0] host_addr_in,
  input  logic [7:0] host_data_in,
  output logic       host_wr_ready_out,
  output logic       cmd_err_out
);

  spi_state_t state, state_nxt;
  spi_cmd_t   cmd_q, cmd_nxt;
  logic [6:0] addr_q, addr_nxt;
  logic [7:0] mask_q, mask_nxt;
  logic [7:0] status_q, status_nxt;
  logic [7:0] regs [0:127];

  logic       cs_active;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       spi_wr;
  logic [6:0] spi_wr_addr;
  logic [7:0] spi_wr_data;
  logic       do_reset;
  logic       cmd_err_nxt;

  spi_slave_byte_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .spi_sck_in (spi_sck_in),
    .spi_cs_n_in(spi_cs_n_in),
    .spi_sdi_in (spi_sdi_in),
    .tx_load    (tx_load),
    .tx_byte    (tx_byte),
    .cs_active  (cs_active),
    .byte_done  (byte_done),
    .rx_byte    (rx_byte),
    .sdo        (spi_sdo_out)
  );

  assign spi_sdo_oe_out    = cs_active && (state == ST_RD_DATA || state == ST_STATUS);
  assign host_wr_ready_out = ~spi_wr;

  // State and command context registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_q    <= CMD_READ;
      addr_q   <= '0;
      mask_q   <= '0;
      status_q <= '0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      addr_q   <= addr_nxt;
      mask_q   <= mask_nxt;
      status_q <= status_nxt;
    end
  end

  // Command decode: next state plus the per-byte datapath controls.
  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cmd_q;
    addr_nxt    = addr_q;
    mask_nxt    = mask_q;
    status_nxt  = status_q;
    tx_load     = 1'b0;
    tx_byte     = '0;
    spi_wr      = 1'b0;
    spi_wr_addr = addr_q;
    spi_wr_data = rx_byte;
    do_reset    = 1'b0;
    cmd_err_nxt = 1'b0;
    if (!cs_active) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_OPCODE;
        ST_OPCODE: begin
          if (byte_done) begin
            case (rx_byte)
              OP_RESET: begin
                do_reset  = 1'b1;
                state_nxt = ST_DONE;
              end
              OP_READ: begin
                cmd_nxt   = CMD_READ;
                state_nxt = ST_ADDR;
              end
              OP_WRITE: begin
                cmd_nxt   = CMD_WRITE;
                state_nxt = ST_ADDR;
              end
              OP_BIT_MODIFY: begin
                cmd_nxt   = CMD_BIT_MODIFY;
                state_nxt = ST_ADDR;
              end
              OP_READ_STATUS: begin
                status_nxt = status_in;
                tx_load    = 1'b1;
                tx_byte    = status_in;
                state_nxt  = ST_STATUS;
              end
              default: begin
                cmd_err_nxt = 1'b1;
                state_nxt   = ST_IGNORE;
              end
            endcase
          end
        end
        ST_ADDR: begin
          if (byte_done) begin
            addr_nxt = rx_byte[6:0];
            case (cmd_q)
              CMD_READ: begin
                tx_load   = 1'b1;
                tx_byte   = regs[rx_byte[6:0]];
                addr_nxt  = rx_byte[6:0] + 7'd1;
                state_nxt = ST_RD_DATA;
              end
              CMD_WRITE:      state_nxt = ST_WR_DATA;
              CMD_BIT_MODIFY: state_nxt = ST_BM_MASK;
              default:        state_nxt = ST_IGNORE;
            endcase
          end
        end
        ST_RD_DATA: begin
          if (byte_done) begin
            tx_load  = 1'b1;
            tx_byte  = regs[addr_q];
            addr_nxt = addr_q + 7'd1;
          end
        end
        ST_WR_DATA: begin
          if (byte_done) begin
            spi_wr   = 1'b1;
            addr_nxt = addr_q + 7'd1;
          end
        end
        ST_BM_MASK: begin
          if (byte_done) begin
            mask_nxt  = rx_byte;
            state_nxt = ST_BM_DATA;
          end
        end
        ST_BM_DATA: begin
          if (byte_done) begin
            spi_wr      = 1'b1;
            spi_wr_data = bit_modify(regs[addr_q], mask_q, rx_byte);
            state_nxt   = ST_DONE;
          end
        end
        ST_STATUS: begin
          if (byte_done) begin
            tx_load = 1'b1;
            tx_byte = status_q;
          end
        end
        ST_DONE, ST_IGNORE: state_nxt = state;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Write notification and error pulses, registered one cycle after byte_done.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      reg_wr_valid_out <= 1'b0;
      reg_wr_addr_out  <= '0;
      reg_wr_data_out  <= '0;
      cmd_err_out      <= 1'b0;
    end else begin
      reg_wr_valid_out <= spi_wr;
      cmd_err_out      <= cmd_err_nxt;
      if (spi_wr) begin
        reg_wr_addr_out <= spi_wr_addr;
        reg_wr_data_out <= spi_wr_data;
      end
    end
  end

  // Register file: reset/RESET command, then SPI commit, then host write.
  // A host write accepted alongside a RESET command lands on top of the reset image.
  always_ff @(posedge sys_clk) begin
    if (reset || do_reset) begin
      for (int i = 0; i < 128; i++) regs[i] <= 8'h00;
      regs[ADDR_CANSTAT] <= CANSTAT_RST;
      regs[ADDR_CANCTRL] <= CANCTRL_RST;
      if (!reset && host_wr_en_in) regs[host_addr_in] <= host_data_in;
    end else if (spi_wr) begin
      regs[spi_wr_addr] <= spi_wr_data;
    end else if (host_wr_en_in) begin
      regs[host_addr_in] <= host_data_in;
    end
  end

endmodule
